// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and frame-length helper
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_CLK_PER_BIT = 1;
    // start bit plus eight data bits; the stop bit already looks like idle
    localparam int UART_FRAME_BITS  = 9;

    function automatic int frame_min_clk(input int clk_per_bit);
        return UART_FRAME_BITS * clk_per_bit;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count and synchronous flush
//   clk_i, nreset_i : clock, synchronous active-low reset
//   clear           : flush, wins over write and read
//   wr_en, wr_data  : write request, ignored while full
//   rd_en, rd_data  : read request (ignored while empty), head entry
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_wr;
    logic              do_rd;

    // full is taken from the registered count, so a read in the same
    // cycle never makes room for a write
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // storage needs no reset; entries are only visible through the count
    always_ff @(posedge clk_i) begin
        if (nreset_i && !clear && do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - frame detector and byte FIFO behind a UART receiver
//   clk_i, nreset_i      : clock, synchronous active-low reset
//   enable_i             : receive enable from control logic
//   clear_i              : flush FIFO and overflow flag
//   rx_ready_i           : receiver idle indication
//   rx_data_i            : receiver data byte
//   rx_valid_o           : receiver enable, gated while full when FLOW_GATE=1
//   m_data_o, m_valid_o  : head byte stream toward host
//   m_ready_i            : host accepts head byte
//   count_o              : FIFO occupancy
//   overflow_o           : sticky, a completed frame was dropped
//   false_start_o        : pulse, busy period too short to be a frame
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT   = UART_CLK_PER_BIT,
    parameter int DEPTH         = 8,
    parameter int FRAME_MIN_CLK = frame_min_clk(CLK_PER_BIT),
    parameter bit FLOW_GATE     = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   rx_ready_i,
    input  logic [UART_DATA_W-1:0] rx_data_i,
    output logic                   rx_valid_o,
    output logic [UART_DATA_W-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   false_start_o
);

    localparam int            BW       = $clog2(FRAME_MIN_CLK + 1);
    localparam logic [BW-1:0] BUSY_SAT = BW'(FRAME_MIN_CLK);

    logic          rx_ready_d;
    logic [BW-1:0] busy_cnt;
    logic          frame_end;
    logic          frame_ok;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow_q;

    // busy tracker: counts receiver-busy clocks, saturating at the frame minimum
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            rx_ready_d <= 1'b1;
            busy_cnt   <= '0;
        end else begin
            rx_ready_d <= rx_ready_i;
            if (rx_ready_i) begin
                busy_cnt <= '0;
            end else if (busy_cnt != BUSY_SAT) begin
                busy_cnt <= busy_cnt + BW'(1);
            end
        end
    end

    // receiver returning to idle ends a busy period; the byte is valid now
    assign frame_end     = nreset_i && !rx_ready_d && rx_ready_i;
    assign frame_ok      = (busy_cnt == BUSY_SAT);
    assign push_req      = frame_end && frame_ok;
    assign false_start_o = frame_end && !frame_ok;

    assign pop        = m_valid_o && m_ready_i;
    assign m_valid_o  = !fifo_empty;
    assign rx_valid_o = nreset_i && enable_i && !(FLOW_GATE && fifo_full);
    assign overflow_o = overflow_q;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    uart_sync_fifo #(
        .DATA_W (UART_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .clear    (clear_i),
        .wr_en    (push_req),
        .wr_data  (rx_data_i),
        .rd_en    (pop),
        .rd_data  (m_data_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count_o)
    );

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side stage directly downstream of the UART receiver. It drives the receiver's enable (valid) input and watches the receiver's ready (idle) output to detect completed frames. It captures each completed byte into a small synchronous FIFO and presents the bytes on a valid/ready stream toward the bus/host logic. It filters false starts and flags overflow.

Parameters:
CLK_PER_BIT, 1, clocks per UART bit; must match the receiver instance
DEPTH, 8, FIFO entries; power of two, at least 2
FRAME_MIN_CLK, 9*CLK_PER_BIT, minimum receiver-busy clocks for a busy period to count as a real frame
FLOW_GATE, 1, 1 = deassert receiver enable while FIFO full; 0 = never gate (overflow possible)

Ports:
clk_i  in  1  system clock
nreset_i  in  1  reset, synchronous, active-low
enable_i  in  1  receive enable from control logic
clear_i  in  1  synchronous flush of FIFO and flags
rx_ready_i  in  1  receiver idle indication (high = receiver in IDLE)
rx_data_i  in  8  receiver data output
rx_valid_o  out  1  drives receiver valid input
m_data_o  out  8  head-of-FIFO byte
m_valid_o  out  1  FIFO not empty
m_ready_i  in  1  consumer accepts head byte
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a completed frame was dropped
false_start_o  out  1  one-cycle pulse: busy period shorter than FRAME_MIN_CLK

Behaviour:
- Reset (nreset_i low at clk_i edge): FIFO empty, count_o=0, m_valid_o=0, overflow_o=0, false_start_o=0, busy counter=0, rx_ready_d=1. m_data_o is don't-care while m_valid_o=0.
- rx_valid_o = enable_i && !(FLOW_GATE && full). This is combinational and is low during reset.
- Busy tracker:
  - rx_ready_d registers rx_ready_i.
  - busy_cnt clears when rx_ready_i=1.
  - While rx_ready_i=0, busy_cnt increments and saturates at FRAME_MIN_CLK. Its width is $clog2(FRAME_MIN_CLK+1).
- Frame end is a rising edge: rx_ready_d=0 && rx_ready_i=1.
  - If busy_cnt==FRAME_MIN_CLK (saturated), the frame is complete and push_req=1.
  - Otherwise, false_start_o=1 for exactly that cycle and nothing is pushed.
- Push:
  - If push_req && !full, rx_data_i is written on that same edge.
  - m_valid_o rises on the next cycle (1-clock latency from the rx_ready_i rise).
  - If push_req && full, the byte is dropped and overflow_o is set. overflow_o stays set until clear_i or reset.
- Pop:
  - A transfer occurs when m_valid_o && m_ready_i on a clock edge. The read pointer advances.
  - m_data_o shows the next entry in the following cycle.
  - m_data_o is stable while m_valid_o=1 and m_ready_i=0.
- Simultaneous push and pop: both execute and count is unchanged.
  - When full, push is rejected even if a pop occurs in the same cycle. The drop is deterministic and overflow is set.
  - When empty, pop cannot happen.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- clear_i has priority over push, pop and the overflow set. It empties the FIFO and clears overflow_o. The busy tracker is unaffected, so a frame in progress still completes and pushes normally after clear.
- enable_i low mid-frame: the receiver ignores its valid input outside IDLE, so the frame completes and is pushed.
- Reset mid-frame: all state is cleared. The next rising edge of rx_ready_i after reset sees busy_cnt < FRAME_MIN_CLK, so it is classed as a false start.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8, default CLK_PER_BIT, and a helper constant for the minimum frame length (9 bit periods).
- One sub-module, uart_sync_fifo (parameters DATA_W, DEPTH):
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, count, clear.
  - Same clock and reset convention.
- Busy tracker, flags and gating stay in uart_rx_buffer.

Test Plan:
1. Single byte: CLK_PER_BIT=4. rx_ready_i low for 40 clk with rx_data_i=8'hA5, then high → push at the rise. m_valid_o=1 one clock later, m_data_o=8'hA5, count_o=1. m_ready_i=1 → count_o=0, m_valid_o=0.
2. False start: rx_ready_i low for 3 clk (< FRAME_MIN_CLK=36), then high → false_start_o pulses 1 clk, count_o stays 0, no m_valid_o.
3. Fill and gate: DEPTH=8, FLOW_GATE=1. Push 8 frames 8'h01..8'h08 with m_ready_i=0 → count_o=8 and rx_valid_o=0 while enable_i=1. Drain → bytes 01..08 in order, and rx_valid_o returns high after the first pop.
4. Overflow: FLOW_GATE=0, FIFO full, a 9th frame with 8'hFF completes → overflow_o=1, count_o=8, head still 8'h01. clear_i=1 → count_o=0, overflow_o=0.
5. Simultaneous push/pop: count_o=3, frame end coincides with m_valid_o&&m_ready_i → count_o stays 3 and the new byte lands at the tail. Also check the wrap-around after more than DEPTH total pushes.
6. Reset mid-frame: nreset_i low for 2 clk during busy, then rx_ready_i rises → no push, false_start_o pulses, and all outputs are at their reset values during reset.
